// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_WIDTH    = 8;
    localparam int INDEX_BITS    = 3;
    localparam int OFFSET_BITS   = 2;
    localparam int TAG_BITS      = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int NUM_SETS      = 1 << INDEX_BITS;
    localparam int BLOCK_BITS    = 32;
    localparam int MEM_ADDR_BITS = TAG_BITS + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BACK,
        MEM_READ,
        UPDATE
    } state_t;

    // Byte k of a block lives at bits [8k+7:8k].
    function automatic logic [7:0] get_byte(input logic [BLOCK_BITS-1:0] block,
                                            input logic [OFFSET_BITS-1:0] k);
        logic [7:0] result;
        case (k)
            2'd0:    result = block[7:0];
            2'd1:    result = block[15:8];
            2'd2:    result = block[23:16];
            default: result = block[31:24];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the data cache. The slave modport is the
// cache's view (it serves the CPU and initiates memory blocks); the master
// modport is the environment's view (CPU plus block memory).
interface dcache_if;

    logic                                   read;
    logic                                   write;
    logic [dcache_pkg::ADDR_WIDTH-1:0]      address;
    logic [7:0]                             writedata;
    logic [7:0]                             readdata;
    logic                                   busywait;
    logic                                   mem_read;
    logic                                   mem_write;
    logic [dcache_pkg::MEM_ADDR_BITS-1:0]   mem_address;
    logic [dcache_pkg::BLOCK_BITS-1:0]      mem_writedata;
    logic [dcache_pkg::BLOCK_BITS-1:0]      mem_readdata;
    logic                                   mem_busywait;

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/dcache_array.sv
// Per-set valid/dirty/tag/data storage with combinational read of one set,
// a CPU byte-write port and a whole-block fill port.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_BITS-1:0]  index,
    output logic                   valid,
    output logic                   dirty,
    output logic [TAG_BITS-1:0]    tag,
    output logic [BLOCK_BITS-1:0]  data,
    input  logic                   byte_we,
    input  logic [OFFSET_BITS-1:0] byte_offset,
    input  logic [7:0]             byte_data,
    input  logic                   fill_we,
    input  logic [TAG_BITS-1:0]    fill_tag,
    input  logic [BLOCK_BITS-1:0]  fill_data
);

    logic [NUM_SETS-1:0]   valid_bits;
    logic [NUM_SETS-1:0]   dirty_bits;
    logic [TAG_BITS-1:0]   tag_mem  [NUM_SETS];
    logic [BLOCK_BITS-1:0] data_mem [NUM_SETS];

    // Status bits: cleared by reset, a fill makes the set clean, a store makes it dirty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill_we) begin
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_bits[index] <= 1'b1;
        end
    end

    // Tag and data payload need no reset; they are meaningless while valid is 0.
    always_ff @(posedge clock) begin
        if (fill_we) begin
            tag_mem[index]  <= fill_tag;
            data_mem[index] <= fill_data;
        end else if (byte_we) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_offset == k[OFFSET_BITS-1:0]) begin
                    data_mem[index][8*k +: 8] <= byte_data;
                end
            end
        end
    end

    assign valid = valid_bits[index];
    assign dirty = dirty_bits[index];
    assign tag   = tag_mem[index];
    assign data  = data_mem[index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller: hit logic,
// CPU stall generation and the miss/write-back state machine.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    dcache_if.slave bus
);

    logic [TAG_BITS-1:0]    addr_tag;
    logic [INDEX_BITS-1:0]  addr_index;
    logic [OFFSET_BITS-1:0] addr_offset;
    logic                   line_valid;
    logic                   line_dirty;
    logic [TAG_BITS-1:0]    line_tag;
    logic [BLOCK_BITS-1:0]  line_data;
    logic                   access;
    logic                   hit;
    logic                   byte_we;
    logic                   fill_we;
    state_t                 state;
    logic                   mem_read_q;
    logic                   mem_write_q;
    logic [MEM_ADDR_BITS-1:0] mem_address_q;
    logic [BLOCK_BITS-1:0]  mem_writedata_q;

    assign addr_tag    = bus.address[ADDR_WIDTH-1 -: TAG_BITS];
    assign addr_index  = bus.address[OFFSET_BITS +: INDEX_BITS];
    assign addr_offset = bus.address[OFFSET_BITS-1:0];

    // A simultaneous read and write is not an access at all.
    assign access  = bus.read ^ bus.write;
    assign hit     = line_valid && (line_tag == addr_tag);
    assign byte_we = (state == IDLE) && bus.write && !bus.read && hit;
    assign fill_we = (state == UPDATE);

    // Reset gates the stall so an aborted transaction releases the CPU at once.
    assign bus.busywait = reset && access && ((state != IDLE) || !hit);
    assign bus.readdata = (reset && (state == IDLE) && bus.read && !bus.write && hit)
                          ? get_byte(line_data, addr_offset) : 8'h00;

    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_writedata = mem_writedata_q;

    dcache_array u_array (
        .clock       (clock),
        .reset       (reset),
        .index       (addr_index),
        .valid       (line_valid),
        .dirty       (line_dirty),
        .tag         (line_tag),
        .data        (line_data),
        .byte_we     (byte_we),
        .byte_offset (addr_offset),
        .byte_data   (bus.writedata),
        .fill_we     (fill_we),
        .fill_tag    (addr_tag),
        .fill_data   (bus.mem_readdata)
    );

    // Miss FSM with registered memory-side outputs; requests drop on the edge that sees memory finish.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !hit) begin
                        if (line_valid && line_dirty) begin
                            state           <= WRITE_BACK;
                            mem_write_q     <= 1'b1;
                            mem_address_q   <= {line_tag, addr_index};
                            mem_writedata_q <= line_data;
                        end else begin
                            state         <= MEM_READ;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {addr_tag, addr_index};
                        end
                    end
                end
                WRITE_BACK: begin
                    if (!bus.mem_busywait) begin
                        state           <= MEM_READ;
                        mem_write_q     <= 1'b0;
                        mem_read_q      <= 1'b1;
                        mem_address_q   <= {addr_tag, addr_index};
                        mem_writedata_q <= '0;
                    end
                end
                MEM_READ: begin
                    if (!bus.mem_busywait) begin
                        state         <= UPDATE;
                        mem_read_q    <= 1'b0;
                        mem_address_q <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a small block-memory model.
module tb_dcache_controller;

    localparam int MEM_LAT   = 3;
    localparam int MAX_WAIT  = 100;

    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    logic [31:0] mem_blocks [64];
    int          mem_cnt;
    logic        mem_done;

    dcache_if bus ();

    dcache_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory busy rises with a request and falls for the one cycle in which the block completes.
    assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && !mem_done;

    // Block memory model: MEM_LAT busy cycles per transaction, done pulse lasts one cycle.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_cnt          <= 0;
            mem_done         <= 1'b0;
            bus.mem_readdata <= 32'h0;
        end else if (mem_done) begin
            mem_done <= 1'b0;
            mem_cnt  <= 0;
        end else if (bus.mem_read || bus.mem_write) begin
            if (mem_cnt == MEM_LAT - 1) begin
                mem_done <= 1'b1;
                if (bus.mem_read)
                    bus.mem_readdata <= mem_blocks[bus.mem_address];
                else
                    mem_blocks[bus.mem_address] <= bus.mem_writedata;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    // Issue one CPU access, follow it until busywait is low, and log memory activity.
    task automatic run_access(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wdata, output int cycles,
                              output logic saw_rd, output logic saw_wr,
                              output logic [5:0] rd_addr, output logic [5:0] wr_addr,
                              output logic [31:0] wr_data, output logic [7:0] data_out,
                              output logic timeout);
        saw_rd  = 1'b0;
        saw_wr  = 1'b0;
        rd_addr = 6'h3f;
        wr_addr = 6'h3f;
        wr_data = 32'h0;
        cycles  = 0;
        @(negedge clock);
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = addr;
        bus.writedata = wdata;
        #1;
        while (bus.busywait === 1'b1 && cycles < MAX_WAIT) begin
            if (bus.mem_read === 1'b1 && !saw_rd) begin
                saw_rd  = 1'b1;
                rd_addr = bus.mem_address;
            end
            if (bus.mem_write === 1'b1 && !saw_wr) begin
                saw_wr  = 1'b1;
                wr_addr = bus.mem_address;
                wr_data = bus.mem_writedata;
            end
            @(negedge clock);
            #1;
            cycles++;
        end
        timeout  = (cycles >= MAX_WAIT);
        data_out = bus.readdata;
        @(negedge clock);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic test_reset();
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = 8'h00;
        bus.writedata = 8'h00;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        compared++;
        if (bus.busywait !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busywait: got %b expected 0", bus.busywait);
        end
        compared++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mem_req: got rd=%b wr=%b expected 0/0", bus.mem_read, bus.mem_write);
        end
        compared++;
        if (bus.readdata !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_readdata: got %h expected 00", bus.readdata);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_read_miss();
        int cyc; logic srd, swr, tmo; logic [5:0] ra, wa; logic [31:0] wd; logic [7:0] d;
        run_access(1'b1, 1'b0, 8'h00, 8'h00, cyc, srd, swr, ra, wa, wd, d, tmo);
        compared++;
        if (tmo !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL miss0_timeout: waited %0d cycles, expected completion", cyc);
        end
        compared++;
        if (srd !== 1'b1 || ra !== 6'h00) begin
            mismatched++;
            $display("[TB] FAIL miss0_mem_read: got seen=%b addr=%h expected 1/00", srd, ra);
        end
        compared++;
        if (swr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL miss0_no_wb: got mem_write seen=%b expected 0", swr);
        end
        compared++;
        if (d !== 8'h11) begin
            mismatched++;
            $display("[TB] FAIL miss0_readdata: got %h expected 11", d);
        end
        compared++;
        if (cyc !== 6) begin
            mismatched++;
            $display("[TB] FAIL miss0_latency: got %0d stall cycles expected 6", cyc);
        end
    endtask

    task automatic test_read_hit();
        int cyc; logic srd, swr, tmo; logic [5:0] ra, wa; logic [31:0] wd; logic [7:0] d;
        logic [7:0] addrs [2];
        logic [7:0] exp_data [2];
        addrs[0] = 8'h01; exp_data[0] = 8'h22;
        addrs[1] = 8'h03; exp_data[1] = 8'h44;
        for (int i = 0; i < 2; i++) begin
            run_access(1'b1, 1'b0, addrs[i], 8'h00, cyc, srd, swr, ra, wa, wd, d, tmo);
            compared++;
            if (cyc !== 0 || srd !== 1'b0 || swr !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL hit_no_stall: addr %h got cycles=%0d rd=%b wr=%b expected 0/0/0",
                         addrs[i], cyc, srd, swr);
            end
            compared++;
            if (d !== exp_data[i]) begin
                mismatched++;
                $display("[TB] FAIL hit_readdata: addr %h got %h expected %h", addrs[i], d, exp_data[i]);
            end
        end
    endtask

    task automatic test_write_miss();
        int cyc; logic srd, swr, tmo; logic [5:0] ra, wa; logic [31:0] wd; logic [7:0] d;
        run_access(1'b0, 1'b1, 8'h05, 8'hAB, cyc, srd, swr, ra, wa, wd, d, tmo);
        compared++;
        if (srd !== 1'b1 || ra !== 6'h01 || swr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wmiss_fill: got rd=%b addr=%h wr=%b expected 1/01/0", srd, ra, swr);
        end
        compared++;
        if (cyc !== 6) begin
            mismatched++;
            $display("[TB] FAIL wmiss_latency: got %0d stall cycles expected 6", cyc);
        end
        run_access(1'b1, 1'b0, 8'h05, 8'h00, cyc, srd, swr, ra, wa, wd, d, tmo);
        compared++;
        if (d !== 8'hAB || cyc !== 0) begin
            mismatched++;
            $display("[TB] FAIL wmiss_byte1: got %h after %0d cycles expected AB after 0", d, cyc);
        end
        run_access(1'b1, 1'b0, 8'h04, 8'h00, cyc, srd, swr, ra, wa, wd, d, tmo);
        compared++;
        if (d !== 8'h00 || cyc !== 0) begin
            mismatched++;
            $display("[TB] FAIL wmiss_byte0: got %h after %0d cycles expected 00 after 0", d, cyc);
        end
    endtask

    task automatic test_dirty_evict();
        int cyc; logic srd, swr, tmo; logic [5:0] ra, wa; logic [31:0] wd; logic [7:0] d;
        run_access(1'b1, 1'b0, 8'h25, 8'h00, cyc, srd, swr, ra, wa, wd, d, tmo);
        compared++;
        if (swr !== 1'b1 || wa !== 6'h01 || wd !== 32'h0000AB00) begin
            mismatched++;
            $display("[TB] FAIL evict_wb: got wr=%b addr=%h data=%h expected 1/01/0000ab00", swr, wa, wd);
        end
        compared++;
        if (srd !== 1'b1 || ra !== 6'h09) begin
            mismatched++;
            $display("[TB] FAIL evict_fill: got rd=%b addr=%h expected 1/09", srd, ra);
        end
        compared++;
        if (d !== 8'hBB) begin
            mismatched++;
            $display("[TB] FAIL evict_readdata: got %h expected bb", d);
        end
        compared++;
        if (cyc !== 10) begin
            mismatched++;
            $display("[TB] FAIL evict_latency: got %0d stall cycles expected 10", cyc);
        end
        compared++;
        if (mem_blocks[1] !== 32'h0000AB00) begin
            mismatched++;
            $display("[TB] FAIL evict_mem_block1: got %h expected 0000ab00", mem_blocks[1]);
        end
        // The freshly filled set is clean, so evicting it must not write back.
        run_access(1'b1, 1'b0, 8'h05, 8'h00, cyc, srd, swr, ra, wa, wd, d, tmo);
        compared++;
        if (swr !== 1'b0 || srd !== 1'b1 || ra !== 6'h01) begin
            mismatched++;
            $display("[TB] FAIL clean_evict: got wr=%b rd=%b addr=%h expected 0/1/01", swr, srd, ra);
        end
        compared++;
        if (d !== 8'hAB) begin
            mismatched++;
            $display("[TB] FAIL clean_evict_data: got %h expected ab", d);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic srd, swr, tmo; logic [5:0] ra, wa; logic [31:0] wd; logic [7:0] d;
        @(negedge clock);
        bus.read    = 1'b1;
        bus.write   = 1'b0;
        bus.address = 8'h08;
        @(negedge clock);
        #1;
        compared++;
        if (bus.mem_read !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midrst_started: got mem_read=%b expected 1", bus.mem_read);
        end
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        compared++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midrst_mem_req: got rd=%b wr=%b expected 0/0", bus.mem_read, bus.mem_write);
        end
        compared++;
        if (bus.busywait !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midrst_busywait: got %b expected 0", bus.busywait);
        end
        bus.read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        run_access(1'b1, 1'b0, 8'h00, 8'h00, cyc, srd, swr, ra, wa, wd, d, tmo);
        compared++;
        if (srd !== 1'b1 || ra !== 6'h00 || cyc !== 6) begin
            mismatched++;
            $display("[TB] FAIL midrst_remiss: got rd=%b addr=%h cycles=%0d expected 1/00/6", srd, ra, cyc);
        end
        compared++;
        if (d !== 8'h11) begin
            mismatched++;
            $display("[TB] FAIL midrst_readdata: got %h expected 11", d);
        end
    endtask

    task automatic test_illegal();
        int cyc; logic srd, swr, tmo; logic [5:0] ra, wa; logic [31:0] wd; logic [7:0] d;
        logic bad_busy;
        logic bad_mem;
        bad_busy = 1'b0;
        bad_mem  = 1'b0;
        @(negedge clock);
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        bus.address   = 8'h30;
        bus.writedata = 8'h5C;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.busywait !== 1'b0) bad_busy = 1'b1;
            if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) bad_mem = 1'b1;
            @(negedge clock);
        end
        bus.read  = 1'b0;
        bus.write = 1'b0;
        compared++;
        if (bad_busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL illegal_busywait: got busywait raised, expected 0");
        end
        compared++;
        if (bad_mem !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL illegal_mem_req: got memory request, expected none");
        end
        run_access(1'b1, 1'b0, 8'h01, 8'h00, cyc, srd, swr, ra, wa, wd, d, tmo);
        compared++;
        if (d !== 8'h22 || cyc !== 0 || srd !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL illegal_after: got %h cycles=%0d rd=%b expected 22/0/0", d, cyc, srd);
        end
        run_access(1'b1, 1'b0, 8'h32, 8'h00, cyc, srd, swr, ra, wa, wd, d, tmo);
        compared++;
        if (srd !== 1'b1 || ra !== 6'h0C || d !== 8'h5A) begin
            mismatched++;
            $display("[TB] FAIL illegal_nostore: got rd=%b addr=%h data=%h expected 1/0c/5a", srd, ra, d);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 64; i++) begin
            mem_blocks[i] = 32'h5A5A_0000 | i;
        end
        mem_blocks[0] = 32'h44332211;
        mem_blocks[1] = 32'h00000000;
        mem_blocks[9] = 32'hDDCCBBAA;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_miss();
        test_dirty_evict();
        test_reset_mid();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
